inst_fetch_unit: RTL
====================

Name: inst_fetch_unit

Overview:
- Front-end fetch stage that sits directly upstream of the core's decode/control path.
- Owns the fetch PC and issues word requests to instruction memory over a valid/ready request channel.
- Collects in-order, variable-latency responses into a small prefetch FIFO and presents {pc, inst} pairs to decode over a valid/ready handshake.
- Handles branch/jump redirects (flush plus discard of in-flight responses) and halt.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset
FIFO_DEPTH, 4, prefetch FIFO entries (power of two, >=2)
CNT_W, $clog2(FIFO_DEPTH)+1, width of occupancy/outstanding counters

Ports:
clk  input  1  clock, all state on rising edge
rst_b  input  1  asynchronous, active-low reset
imem_req_valid  output  1  request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  word address requested (= fetch_pc)
imem_resp_valid  input  1  response word valid (in order, no backpressure)
imem_resp_data  input  32  response instruction word
dec_valid  output  1  FIFO head valid
dec_ready  input  1  decode consumes head
dec_inst  output  32  head instruction
dec_pc  output  32  head instruction address
redirect_valid  input  1  one-cycle redirect pulse from branch/jump resolution
redirect_pc  input  32  redirect target
halt  input  1  level; stop issuing new requests
fetch_idle  output  1  no outstanding requests and FIFO empty

Behaviour:
- Reset (async, rst_b=0):
  - fetch_pc=resp_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0.
  - Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, dec_valid=0, dec_inst=0, dec_pc=0, fetch_idle=1.
  - Reset mid-operation discards everything. Instruction memory shares rst_b, so no stale responses arrive after reset.
- Request channel:
  - imem_req_valid = !rst_state && !halt && !redirect_valid && (fifo_count + outstanding < FIFO_DEPTH). Combinational from registered state plus halt/redirect.
  - On valid&ready: fetch_pc <= fetch_pc+4 (wraps mod 2^32), outstanding+1.
  - imem_req_addr = fetch_pc, stable while valid&&!ready unless a redirect occurs.
- Response handling (every imem_resp_valid decrements outstanding):
  - If drop_cnt>0: discard the word, drop_cnt-1.
  - Else: push {resp_pc, imem_resp_data} into the FIFO, resp_pc <= resp_pc+4.
  - The credit rule guarantees the FIFO never overflows.
  - imem_resp_valid with outstanding==0 is a protocol violation: ignored, flagged by assertion.
- Decode side:
  - dec_valid = FIFO non-empty; dec_inst/dec_pc = head, registered FIFO storage.
  - Pop on dec_valid&&dec_ready.
  - Latency: response accepted in cycle N appears at dec_valid in cycle N+1.
  - Push and pop in the same cycle is allowed, count unchanged. A pop when empty is ignored.
- Redirect cycle (redirect_valid=1), highest priority:
  - FIFO flushed and dec_valid forced 0, so no pop occurs.
  - Any response arriving this cycle is discarded.
  - No request is issued.
  - fetch_pc <= redirect_pc; resp_pc <= redirect_pc.
  - drop_cnt <= outstanding - imem_resp_valid, so every remaining in-flight response is dropped.
  - Back-to-back redirects: each recomputes drop_cnt the same way; the last target wins.
- Halt:
  - Suppresses new requests only.
  - In-flight responses are still accepted (or dropped) and the FIFO still drains.
  - Deasserting halt resumes at the current fetch_pc.
  - Redirect while halted updates the PCs normally.
- fetch_idle = (outstanding==0) && FIFO empty, combinational from state.
- Counter invariants: fifo_count + outstanding <= FIFO_DEPTH; drop_cnt <= outstanding. Both are asserted.

Test Plan:
- Streaming:
  - Stimulus: reset, imem_req_ready=1, 1-cycle memory, dec_ready=1, halt=0.
  - Required: requests at 0x0, 0x4, 0x8, ...; dec_pc sequence 0x0, 0x4, 0x8 with matching data; dec_valid first high 2 cycles after the first request acceptance.
- Backpressure fill:
  - Stimulus: dec_ready=0.
  - Required: exactly 4 requests issued (0x0–0xC), then imem_req_valid=0 with FIFO full.
  - Stimulus: then dec_ready=1 for one cycle.
  - Required: one pop, and one new request for 0x10 the following cycle.
- Redirect with in-flight:
  - Stimulus: 3-cycle memory latency, 2 requests outstanding; pulse redirect_valid with redirect_pc=0x100.
  - Required: FIFO flushed; next 2 responses dropped; first dec_pc after redirect = 0x100; no 0x8/0xC instructions delivered.
- Redirect coincident with response:
  - Stimulus: response arrives in the redirect cycle with outstanding=1.
  - Required: drop_cnt=0; the next response (for the target) is delivered.
- Halt:
  - Stimulus: assert halt with 2 requests outstanding.
  - Required: no new imem_req_valid; both responses delivered; fetch_idle=1 after FIFO drains.
  - Stimulus: deassert halt.
  - Required: fetching resumes at the next sequential PC.
- Async reset mid-stream:
  - Stimulus: drop rst_b between clock edges while the FIFO holds data.
  - Required: dec_valid=0, imem_req_addr=RESET_PC immediately (before the next clock edge); refetch from 0x0 after release.

Source files
------------

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : inst_fetch_unit                                                |
// | Brief    : Fetch stage with credit-based request issue, in-order response |
// |            prefetch FIFO and redirect/halt handling.                      |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst_b,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        fetch_idle
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);

  logic [31:0]        r_fetch_pc;
  logic [31:0]        r_resp_pc;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_outstanding;
  logic [CNT_W-1:0]   r_drop_cnt;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [31:0]        r_pc_mem   [FIFO_DEPTH];
  logic [31:0]        r_inst_mem [FIFO_DEPTH];

  logic [CNT_W:0]     w_occupancy;
  logic               w_req_valid;
  logic               w_req_fire;
  logic               w_resp_ok;
  logic               w_push;
  logic               w_dec_valid;
  logic               w_pop;

  // Slots are reserved at request time, so FIFO entries plus in-flight words
  // can never exceed the FIFO depth and the response path needs no backpressure.
  assign w_occupancy = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_req_valid = rst_b && !halt && !redirect_valid &&
                       (w_occupancy < (CNT_W+1)'(FIFO_DEPTH));
  assign w_req_fire  = w_req_valid && imem_req_ready;
  assign w_resp_ok   = imem_resp_valid && (r_outstanding != '0);
  assign w_push      = w_resp_ok && !redirect_valid && (r_drop_cnt == '0);
  assign w_dec_valid = (r_count != '0) && !redirect_valid;
  assign w_pop       = w_dec_valid && dec_ready;

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign dec_valid      = w_dec_valid;
  assign dec_inst       = r_inst_mem[r_rd_ptr];
  assign dec_pc         = r_pc_mem[r_rd_ptr];
  assign fetch_idle     = (r_outstanding == '0) && (r_count == '0);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= r_outstanding + CNT_W'(w_req_fire) - CNT_W'(w_resp_ok);
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc;
        r_resp_pc  <= redirect_pc;
        // Everything still in flight after this cycle belongs to the old path.
        r_drop_cnt <= r_outstanding - CNT_W'(w_resp_ok);
      end else begin
        if (w_req_fire)
          r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_push)
          r_resp_pc <= r_resp_pc + 32'd4;
        if (w_resp_ok && (r_drop_cnt != '0))
          r_drop_cnt <= r_drop_cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_pc_mem[i]   <= '0;
        r_inst_mem[i] <= '0;
      end
    end else if (redirect_valid) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_push) begin
        r_pc_mem[r_wr_ptr]   <= r_resp_pc;
        r_inst_mem[r_wr_ptr] <= imem_resp_data;
        r_wr_ptr             <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_b) begin
      assert (!(imem_resp_valid && (r_outstanding == '0)));
      assert (w_occupancy <= (CNT_W+1)'(FIFO_DEPTH));
      assert (r_drop_cnt <= r_outstanding);
    end
  end
`endif

endmodule
`default_nettype wire
